// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage program-counter generator.
package pc_pkg;

  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_JALR   = 2'b01;
  localparam logic [1:0] SEL_RAS    = 2'b10;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; the oldest entry is overwritten on overflow.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [CW-1:0]   count;
  logic            pop_eff;

  assign empty   = (count == '0);
  assign top     = mem[top_ptr];
  assign pop_eff = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push && !pop_eff) begin
      top_ptr <= top_ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop_eff && !push) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - CW'(1);
    end
  end

  // Simultaneous push and pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop_eff) mem[top_ptr] <= push_addr;
      else         mem[top_ptr + PW'(1)] <= push_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch PC with trap/redirect priority and misalignment fault.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
//
// state | meaning
// BOOT  | one bubble after reset, pc_valid low
// RUN   | presenting pc to fetch, pc_valid high
// FAULT | misaligned target seen, fetch halted until trap
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  pc_state_e       state;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;

  assign branch_target = ex_pc + immediate;
  assign jalr_target   = (rs1_data + immediate) & ~XLEN'(1);

`ifdef PC_GEN_RAS_EN
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_pop;

  // Pop only when the redirect is actually taken this edge.
  assign ras_pop = redirect_valid & (state == RUN) & ~trap_valid & (redirect_sel == SEL_RAS);

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .push_addr (ras_push_addr),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_push_addr};
`endif

  always_comb begin
    target = branch_target;
    case (redirect_sel)
      SEL_JALR: target = jalr_target;
`ifdef PC_GEN_RAS_EN
      SEL_RAS:  target = ras_empty ? jalr_target : ras_top;
`else
      SEL_RAS:  target = jalr_target;
`endif
      default:  target = branch_target;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (trap_valid) begin
      state    <= RUN;
      pc       <= trap_vector & ~XLEN'(3);
      pc_valid <= 1'b1;
      fault    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (redirect_valid) begin
            if (target[1:0] != 2'b00) begin
              state      <= FAULT;
              pc_valid   <= 1'b0;
              fault      <= 1'b1;
              fault_addr <= target;
            end else begin
              pc <= target;
            end
          end else if (!stall && fetch_ready) begin
            pc <= pc + XLEN'(INSTR_BYTES);
          end
        end
        FAULT: ;
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed plan plus randomized traffic vs a queue-based model.
module tb_pc_gen;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, stall, redirect_valid, trap_valid, ras_push;
  logic [1:0]  redirect_sel;
  logic [31:0] ex_pc, immediate, rs1_data, trap_vector, ras_push_addr;
  logic [31:0] pc, fault_addr;
  logic        pc_valid, fault;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .ex_pc(ex_pc), .immediate(immediate), .rs1_data(rs1_data),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr),
    .pc(pc), .pc_valid(pc_valid), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  exp_t        q_exp[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_faddr;
  bit          m_boot, m_faulted;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_target();
    logic [31:0] jalr;
    jalr = (rs1_data + immediate) & 32'hFFFF_FFFE;
    if (redirect_sel == 2'b01) return jalr;
    if (redirect_sel == 2'b10) begin
`ifdef PC_GEN_RAS_EN
      if (m_ras.size() > 0) return m_ras.pop_back();
`endif
      return jalr;
    end
    return ex_pc + immediate;
  endfunction

  task automatic model_step();
    exp_t        e;
    bit          running;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RV; m_boot = 1; m_faulted = 0; m_faddr = '0;
      m_ras.delete();
    end else begin
      running = !m_boot && !m_faulted;
      if (trap_valid) begin
        m_pc = trap_vector & 32'hFFFF_FFFC;
        m_faulted = 0;
      end else if (redirect_valid && running) begin
        tgt = ref_target();
        if (tgt % 4 != 0) begin
          m_faulted = 1;
          m_faddr = tgt;
        end else m_pc = tgt;
      end else if (!stall && running && fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
      m_boot = 0;
`ifdef PC_GEN_RAS_EN
      if (ras_push) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
`endif
    end
    e.pc = m_pc; e.valid = !m_boot && !m_faulted; e.fault = m_faulted; e.faddr = m_faddr;
    q_exp.push_back(e);
  endtask

  // Inputs are set at a falling edge; the expectation is queued for the next rising edge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_ready = 0; stall = 0; redirect_valid = 0; redirect_sel = 2'b00;
    ex_pc = '0; immediate = '0; rs1_data = '0; trap_valid = 0; trap_vector = '0;
    ras_push = 0; ras_push_addr = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_valid", {31'b0, pc_valid}, {31'b0, e.valid});
        chk("sb_fault", {31'b0, fault}, {31'b0, e.fault});
        chk("sb_faddr", fault_addr, e.faddr);
      end
    end
  end

  initial begin : stim
    idle_inputs();
    rst = 1;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);

    // boot bubble, then sequential advance
    rst = 0;
    step();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'b0, pc_valid}, 32'h1);
    fetch_ready = 1;
    step(); chk("seq4", pc, 32'h4);
    step(); chk("seq8", pc, 32'h8);
    step(); chk("seqC", pc, 32'hC);
    step(); chk("seq10", pc, 32'h10);

    // handshake hold and stall
    fetch_ready = 0;
    step(); step(); chk("hold", pc, 32'h10);
    stall = 1; fetch_ready = 1;
    step(); chk("stall", pc, 32'h10);
    stall = 0;
    step(); chk("resume", pc, 32'h14);

    // branch under stall, then JALR
    fetch_ready = 0; stall = 1; redirect_valid = 1;
    redirect_sel = 2'b00; ex_pc = 32'h100; immediate = 32'hFFFF_FFFC;
    step(); chk("branch", pc, 32'hFC);
    stall = 0; redirect_sel = 2'b01; rs1_data = 32'h11; immediate = 32'h4;
    step(); chk("jalr", pc, 32'h14);

    // misaligned target, then trap recovery
    redirect_sel = 2'b00; ex_pc = 32'h100; immediate = 32'h2;
    step();
    chk("flt_pc", pc, 32'h14);
    chk("flt_valid", {31'b0, pc_valid}, 32'h0);
    chk("flt_flag", {31'b0, fault}, 32'h1);
    chk("flt_addr", fault_addr, 32'h102);
    redirect_sel = 2'b01; rs1_data = 32'h40; immediate = 32'h0;
    step(); chk("flt_ignore_redir", pc, 32'h14);
    redirect_valid = 0; trap_valid = 1; trap_vector = 32'h203;
    step();
    chk("trap_pc", pc, 32'h200);
    chk("trap_fault", {31'b0, fault}, 32'h0);
    chk("trap_valid", {31'b0, pc_valid}, 32'h1);

    // priority trap > redirect > stall, then wrap
    trap_vector = 32'hFFFF_FFFC; redirect_valid = 1; redirect_sel = 2'b00;
    ex_pc = 32'h100; immediate = 32'h0; stall = 1;
    step(); chk("prio", pc, 32'hFFFF_FFFC);
    trap_valid = 0; redirect_valid = 0; stall = 0; fetch_ready = 1;
    step(); chk("wrap", pc, 32'h0);

    // redirect during boot is ignored
    rst = 1; step(); rst = 0;
    redirect_valid = 1; redirect_sel = 2'b00; ex_pc = 32'h400; immediate = 32'h0;
    step(); chk("boot_redir", pc, RV);
    idle_inputs();

`ifdef PC_GEN_RAS_EN
    ras_push = 1; ras_push_addr = 32'h40; step();
    ras_push_addr = 32'h80; step();
    ras_push = 0; redirect_valid = 1; redirect_sel = 2'b10;
    step(); chk("ras_pop1", pc, 32'h80);
    step(); chk("ras_pop2", pc, 32'h40);
    rs1_data = 32'h20; immediate = 32'h0;
    step(); chk("ras_empty", pc, 32'h20);
    redirect_valid = 0; ras_push = 1;
    for (int i = 1; i <= 5; i++) begin
      ras_push_addr = 32'h100 * i;
      step();
    end
    ras_push = 0; redirect_valid = 1;
    for (int i = 5; i >= 2; i--) begin
      step(); chk("ras_ovf", pc, 32'h100 * i);
    end
    idle_inputs();
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      fetch_ready    = $urandom_range(0, 1);
      stall          = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 4) == 0);
      redirect_sel   = 2'($urandom_range(0, 3));
      ex_pc          = $urandom & 32'hFFFF_FFFC;
      immediate      = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rs1_data       = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      trap_valid     = ($urandom_range(0, 19) == 0);
      trap_vector    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF7 : $urandom;
      ras_push       = ($urandom_range(0, 3) == 0);
      ras_push_addr  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step();
    end

    rst = 0;
    idle_inputs();
    step();
    @(posedge clk); #2;
    chk("sb_drained", q_exp.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered program-counter generator for the fetch stage, replacing the combinational next-PC select.
- Holds the current PC and presents it to instruction fetch with a valid/ready handshake.
- Applies execute-stage redirects (branch, JAL, JALR) and traps by fixed priority, and detects misaligned targets.
- Sits between the execute stage (redirect sources) and the instruction memory port.

Parameters:
- XLEN, 32, datapath and address width in bits.
- RESET_VECTOR, 32'h00000000, PC value loaded by reset.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2; only used when PC_GEN_RAS_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  fetch port accepts pc this cycle.
- stall  in  1  pipeline hazard; blocks sequential advance.
- redirect_valid  in  1  execute stage requests a control transfer.
- redirect_sel  in  2  00 = ex_pc+immediate, 01 = (rs1_data+immediate) with bit 0 cleared, 10 = RAS pop, 11 = reserved (treated as 00).
- ex_pc  in  XLEN  PC of the redirecting instruction.
- immediate  in  XLEN  sign-extended offset.
- rs1_data  in  XLEN  JALR base register.
- trap_valid  in  1  trap/exception entry.
- trap_vector  in  XLEN  trap handler address; bits [1:0] ignored and forced to 0.
- ras_push  in  1  push ras_push_addr (call).
- ras_push_addr  in  XLEN  return address to push.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- fault  out  1  misaligned target detected; fetch halted.
- fault_addr  out  XLEN  offending target address.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_VECTOR, pc_valid=0, fault=0, fault_addr=0.
  - FSM enters BOOT; RAS is emptied.
- FSM states are BOOT, RUN and FAULT.
  - BOOT: after reset deasserts, moves to RUN on the first clock edge. pc_valid=0 while in BOOT (one bubble).
  - RUN: pc_valid=1.
  - FAULT: pc_valid=0, fault=1. Leaves FAULT only on trap_valid.
- Per-edge priority, highest first:
  1. trap_valid: pc <= {trap_vector[XLEN-1:2],2'b00}, state <= RUN, fault <= 0. Applies in any state, including BOOT.
  2. redirect_valid (RUN only): compute target; if target[1:0]!=0 then pc holds, state <= FAULT, fault_addr <= target. Otherwise pc <= target.
  3. stall: pc holds.
  4. pc_valid & fetch_ready: pc <= pc+4.
  5. Otherwise pc holds.
- Redirect and trap override stall and ignore fetch_ready. Redirect is applied on the next edge with no added bubble.
- redirect_valid in BOOT or FAULT is ignored.
- Arithmetic: all sums are XLEN-bit modulo 2^XLEN; carry is dropped. Example: pc=FFFFFFFC advancing gives 00000000.
- pc is stable while pc_valid & ~fetch_ready (handshake hold), unless a trap or redirect occurs.
- Reset asserted mid-operation: immediate async return to BOOT values; any pending redirect is lost.

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular return-address stack with a count saturating at RAS_DEPTH.
  - ras_push writes the top. On overflow the oldest entry is overwritten and count stays at RAS_DEPTH.
  - redirect_sel=10 pops the top as target and decrements count. If empty, it falls back to the 01 target.
  - Push and pop on the same edge: target = old top, new top = ras_push_addr, count unchanged.
  - A trap does not alter the RAS.
- Undefined:
  - No storage; ras_push and ras_push_addr are ignored.
  - redirect_sel=10 behaves exactly as 01.

Decomposition:
- Shared package pc_pkg:
  - redirect_sel encodings SEL_BRANCH=2'b00, SEL_JALR=2'b01, SEL_RAS=2'b10.
  - FSM state enum (BOOT, RUN, FAULT).
  - Constant INSTR_BYTES=4.
- One sub-module, pc_ras (stack storage plus pointer/count), instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Reset: rst=1 then released; first edge after release gives pc=00000000, pc_valid=1. With fetch_ready=1 for 3 edges, pc=00000004, 00000008, 0000000C.
- Handshake and stall: pc=00000010 with fetch_ready=0 for 2 cycles, then stall=1 with fetch_ready=1 for 1 cycle → pc stays 00000010 throughout. Next edge with stall=0 gives 00000014.
- Branch and JALR: redirect_sel=00, ex_pc=00000100, immediate=FFFFFFFC, stall=1 → next pc=000000FC. Then redirect_sel=01, rs1_data=00000011, immediate=00000004 → pc=00000014.
- Fault and recovery: redirect_sel=00, ex_pc=00000100, immediate=00000002 → pc unchanged, pc_valid=0, fault=1, fault_addr=00000102. Then trap_valid=1 with trap_vector=00000203 → pc=00000200, fault=0, pc_valid=1.
- Priority: trap_valid, redirect_valid and stall all asserted on the same edge → pc = trap vector. Also, pc=FFFFFFFC advancing gives pc=00000000 (wrap).
- RAS (PC_GEN_RAS_EN): push 00000040, 00000080, then pop → pc=00000080. Pop again → 00000040. Pop on empty with rs1_data=00000020, immediate=0 → 00000020. Push 5 entries with RAS_DEPTH=4, then pop 4 → 5th, 4th, 3rd, 2nd addresses.
